// File: rtl/pipo_rr_loader_pkg.sv
// Shared types and helpers for the round-robin PIPO loader and its picker.
package pipo_rr_loader_pkg;

  localparam int MAX_N = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Index width for n items, never narrower than one bit
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
    logic [MAX_N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pipo_rr_loader_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module pipo_rr_loader_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] g,
  output logic             any_req
);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_idx [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IDX_W:0] w_sum;
    // ptr is always below N, so one conditional subtract wraps the sum
    assign w_sum       = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign w_idx[gi]   = (w_sum >= (IDX_W+1)'(N)) ? IDX_W'(w_sum - (IDX_W+1)'(N))
                                                  : w_sum[IDX_W-1:0];
    assign w_rot[gi]   = req[w_idx[gi]];
  end

  always_comb begin
    g       = ptr;
    any_req = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) g = w_idx[k];
    end
  end

endmodule

// File: rtl/pipo_rr_loader.sv
// Round-robin loader sharing one W-bit PIPO register among N requesters;
// grants, loads the winner's word, then holds it until the consumer releases it.
module pipo_rr_loader
  import pipo_rr_loader_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 4,
  parameter int MIN_HOLD = 2,
  localparam int IDX_W   = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_data,
  input  logic             consume,
  output logic [N-1:0]     ack,
  output logic [W-1:0]     po,
  output logic             po_valid,
  output logic [IDX_W-1:0] owner
);

  localparam int             CNT_W   = idx_w(MIN_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_HOLD - 1);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_ptr, w_ptr_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [W-1:0]     r_po, w_po_next;
  logic             r_po_valid, w_po_valid_next;
  logic [N-1:0]     r_ack, w_ack_next;
  logic [IDX_W-1:0] r_owner, w_owner_next;

  logic [IDX_W-1:0] w_g;
  logic             w_any_req;
  logic [W-1:0]     w_words [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign w_words[gi] = req_data[gi*W +: W];
  end

  pipo_rr_loader_rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .g       (w_g),
    .any_req (w_any_req)
  );

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_cnt_next      = r_cnt;
    w_po_next       = r_po;
    w_po_valid_next = r_po_valid;
    w_ack_next      = '0;
    w_owner_next    = r_owner;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_po_next       = w_words[w_g];
          w_owner_next    = w_g;
          w_ack_next      = N'(onehot(3'(w_g)));
          w_po_valid_next = 1'b1;
          w_ptr_next      = (w_g == IDX_W'(N - 1)) ? '0 : w_g + 1'b1;
          w_cnt_next      = '0;
          w_state_next    = HOLD;
        end
      end
      HOLD: begin
        if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + 1'b1;
        // Release only once the minimum hold has elapsed; po keeps its word
        if (consume && (r_cnt == CNT_MAX)) begin
          w_po_valid_next = 1'b0;
          w_state_next    = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_po       <= '0;
      r_po_valid <= 1'b0;
      r_ack      <= '0;
      r_owner    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_cnt      <= w_cnt_next;
      r_po       <= w_po_next;
      r_po_valid <= w_po_valid_next;
      r_ack      <= w_ack_next;
      r_owner    <= w_owner_next;
    end
  end

  assign ack      = r_ack;
  assign po       = r_po;
  assign po_valid = r_po_valid;
  assign owner    = r_owner;

endmodule
